nmi_scheduler: RTL and testbench
================================

NMI_SCHEDULER -- requirements
Module: nmi_scheduler

Interface
REQ-001 The block SHALL have the port clk28, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port bus, cpu_bus interface, and SHALL use only its mreq, m1, rd, wr, ioreq, a[15:0] and d[7:0] signals.
REQ-004 The block SHALL have the port req_magic, input, 1 bit: magic-button NMI request, level, already synchronous to clk28.
REQ-005 The block SHALL have the port req_div, input, 1 bit: divmmc NMI request, level.
REQ-006 The block SHALL have the port req_pause, input, 1 bit: pause-button NMI request, level.
REQ-007 The block SHALL have the ports n_int and n_int_next, input, 1 bit each: current and next-cycle frame interrupt.
REQ-008 The block SHALL have the port inhibit, input, 1 bit: when 1, no new NMI is started (magic mode active).
REQ-009 The block SHALL have the port magic_map, input, 1 bit: enables access to the scheduler I/O port.
REQ-010 The block SHALL have the port n_nmi, output, 1 bit: NMI to the CPU, active low.
REQ-011 The block SHALL have the port nmi_busy, output, 1 bit: 1 in every state except IDLE.
REQ-012 The block SHALL have the ports d_out, output, 8 bits, and d_out_active, output, 1 bit: read-back data and its bus-drive enable.

Function
REQ-013 A 0->1 edge on any request input SHALL set that source's pending bit; a pending bit stays set until its source is granted.
REQ-014 If a request edge and the grant of the same source occur in the same cycle, set SHALL win and the pending bit SHALL stay 1.
REQ-015 The FSM SHALL have four states: IDLE, WAIT_SYNC, ASSERT, ACKED.
REQ-016 IDLE -> WAIT_SYNC SHALL occur when any pending bit is 1 and inhibit is 0.
REQ-017 In WAIT_SYNC, when n_int==1 and n_int_next==0, the block SHALL move to ASSERT on the next cycle and drive n_nmi=0.
REQ-018 On that same transition, the block SHALL latch cause[2:0] by fixed priority magic > div > pause as a one-hot value {pause,div,magic}, and SHALL clear that source's pending bit.
REQ-019 If inhibit rises while in WAIT_SYNC, the block SHALL return to IDLE with pending bits unchanged.
REQ-020 ASSERT -> ACKED SHALL occur on the first cycle with m1 && mreq && a==16'h0066, and n_nmi SHALL return to 1 on that transition.
REQ-021 ACKED -> IDLE SHALL occur on an I/O write (magic_map && ioreq && wr) to a==16'h10FF, with any data.
REQ-022 cause SHALL hold its value until the next grant.
REQ-023 An I/O read (magic_map && ioreq && rd && a==16'h10FF) SHALL set d_out_active=1 one cycle later, registered.
REQ-024 d_out SHALL equal {pending_pause, pending_div, pending_magic, timeout_flag, 1'b0, cause[2:0]}.
REQ-025 Without magic_map, the port SHALL be invisible: no state change and d_out_active=0.

Reset
REQ-026 On rst_n=0, the block SHALL immediately force n_nmi=1, state=IDLE, pending=0, cause=0, timeout_flag=0, d_out_active=0 and the counter to 0.
REQ-027 A reset asserted in mid-sequence (ASSERT or ACKED) SHALL abandon the NMI with no residual pending bits.
REQ-028 After reset release, a request input that is already high SHALL NOT register until it has fallen and risen again.

Configuration
REQ-029 With NMI_SCHEDULER_TIMEOUT_EN defined, a 16-bit counter SHALL count clk28 cycles in ASSERT.
REQ-030 With NMI_SCHEDULER_TIMEOUT_EN defined, reaching 16'hFFFF without an acknowledge SHALL force n_nmi=1, set timeout_flag, return to IDLE, and leave cause intact.
REQ-031 With NMI_SCHEDULER_TIMEOUT_EN defined, timeout_flag SHALL clear on the next grant.
REQ-032 Without NMI_SCHEDULER_TIMEOUT_EN, the counter SHALL be absent, timeout_flag SHALL be constant 0, and ASSERT SHALL wait indefinitely.

Verification
REQ-033 The bench SHALL cover: req_magic pulse, inhibit=0, then frame edge -> n_nmi=0 on the next cycle; fetch at 0x0066 -> n_nmi=1; read 0x10FF -> 8'h01.
REQ-034 The bench SHALL cover: req_pause and req_div rising in the same cycle -> first grant cause=3'b010, second grant after a 0x10FF write cause=3'b100; read between the grants -> 8'h82.
REQ-035 The bench SHALL cover: inhibit=1 with req_magic pending across three frames -> n_nmi stays 1; inhibit=0 -> NMI at the next frame edge.
REQ-036 The bench SHALL cover: with NMI_SCHEDULER_TIMEOUT_EN, no 0x0066 fetch for 65535 cycles -> n_nmi=1, state IDLE, read -> 8'h11 for a magic cause.
REQ-037 The bench SHALL cover: rst_n pulsed low during ASSERT -> n_nmi=1 asynchronously; held req_magic gives no NMI until it is re-pulsed.
REQ-038 The bench SHALL cover: a 0x10FF read or write with magic_map=0 -> d_out_active=0 and the state stays ACKED.

Source files
------------

// File: rtl/nmi_scheduler_if.sv
// CPU bus bundle (interface cpu_bus) seen by the NMI scheduler: Z80-style
// strobes, address and data.
interface cpu_bus;
    logic        mreq;
    logic        m1;
    logic        rd;
    logic        wr;
    logic        ioreq;
    logic [15:0] a;
    logic [7:0]  d;

    modport master (output mreq, m1, rd, wr, ioreq, a, d);
    modport slave  (input  mreq, m1, rd, wr, ioreq, a, d);
endinterface

// File: rtl/nmi_scheduler.sv
// NMI scheduler: latches magic/divmmc/pause requests and issues one NMI per
// frame edge. Optional ASSERT-state timeout via `define NMI_SCHEDULER_TIMEOUT_EN.
module nmi_scheduler (
    input  logic       clk28,
    input  logic       rst_n,
    cpu_bus.slave      bus,
    input  logic       req_magic,
    input  logic       req_div,
    input  logic       req_pause,
    input  logic       n_int,
    input  logic       n_int_next,
    input  logic       inhibit,
    input  logic       magic_map,
    output logic       n_nmi,
    output logic       nmi_busy,
    output logic [7:0] d_out,
    output logic       d_out_active
);

    localparam int unsigned SRC_W = 3;
    localparam int unsigned CNT_W = 16;
    localparam logic [15:0] NMI_VEC   = 16'h0066;
    localparam logic [15:0] PORT_ADDR = 16'h10FF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SYNC = 2'd1,
        S_ASSERT    = 2'd2,
        S_ACKED     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   req_prev_q, req_prev_d;
    logic [SRC_W-1:0]   pending_q, pending_d;
    logic [SRC_W-1:0]   cause_q, cause_d;
    logic               n_nmi_q, n_nmi_d;
    logic               nmi_busy_q, nmi_busy_d;
    logic [7:0]         d_out_q, d_out_d;
    logic               d_out_active_q, d_out_active_d;
    logic               timeout_flag;

    logic [SRC_W-1:0]   req_vec;
    logic [SRC_W-1:0]   req_rise;
    logic [SRC_W-1:0]   grant_sel;
    logic [SRC_W-1:0]   grant_mask;
    logic               ack_fetch;
    logic               port_hit;
    logic               port_wr;
    logic               port_rd;
    logic               frame_edge;

`ifdef NMI_SCHEDULER_TIMEOUT_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // Bus decode and request edge detection
    always_comb begin
        req_vec    = {req_pause, req_div, req_magic};
        req_rise   = req_vec & ~req_prev_q;
        req_prev_d = req_vec;
        ack_fetch  = bus.m1 && bus.mreq && (bus.a == NMI_VEC);
        port_hit   = magic_map && bus.ioreq && (bus.a == PORT_ADDR);
        port_wr    = port_hit && bus.wr;
        port_rd    = port_hit && bus.rd;
        frame_edge = n_int && !n_int_next;
        if (pending_q[0])      grant_sel = 3'b001;
        else if (pending_q[1]) grant_sel = 3'b010;
        else if (pending_q[2]) grant_sel = 3'b100;
        else                   grant_sel = 3'b000;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        n_nmi_d    = n_nmi_q;
        cause_d    = cause_q;
        grant_mask = '0;
`ifdef NMI_SCHEDULER_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((|pending_q) && !inhibit) state_d = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                if (inhibit) begin
                    state_d = S_IDLE;
                end else if (frame_edge) begin
                    state_d    = S_ASSERT;
                    n_nmi_d    = 1'b0;
                    cause_d    = grant_sel;
                    grant_mask = grant_sel;
`ifdef NMI_SCHEDULER_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            S_ASSERT: begin
                if (ack_fetch) begin
                    state_d = S_ACKED;
                    n_nmi_d = 1'b1;
`ifdef NMI_SCHEDULER_TIMEOUT_EN
                end else if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d   = S_IDLE;
                    n_nmi_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_ACKED: begin
                if (port_wr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A request edge in the grant cycle re-arms the same source
        pending_d      = (pending_q & ~grant_mask) | req_rise;
        nmi_busy_d     = (state_d != S_IDLE);
        d_out_active_d = port_rd;
        d_out_d        = {pending_q, timeout_flag, 1'b0, cause_q};
    end

    // Prev-request flops reset high so a level held through reset is ignored
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            req_prev_q     <= '1;
            pending_q      <= '0;
            cause_q        <= '0;
            n_nmi_q        <= 1'b1;
            nmi_busy_q     <= 1'b0;
            d_out_q        <= '0;
            d_out_active_q <= 1'b0;
`ifdef NMI_SCHEDULER_TIMEOUT_EN
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            req_prev_q     <= req_prev_d;
            pending_q      <= pending_d;
            cause_q        <= cause_d;
            n_nmi_q        <= n_nmi_d;
            nmi_busy_q     <= nmi_busy_d;
            d_out_q        <= d_out_d;
            d_out_active_q <= d_out_active_d;
`ifdef NMI_SCHEDULER_TIMEOUT_EN
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign n_nmi        = n_nmi_q;
    assign nmi_busy     = nmi_busy_q;
    assign d_out        = d_out_q;
    assign d_out_active = d_out_active_q;

endmodule

// File: tb/tb_nmi_scheduler.sv
// Directed self-checking bench for nmi_scheduler.
module tb_nmi_scheduler;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       req_magic, req_div, req_pause;
    logic       n_int, n_int_next;
    logic       inhibit, magic_map;
    logic       n_nmi, nmi_busy;
    logic [7:0] d_out;
    logic       d_out_active;

    int errors = 0;
    int checks = 0;

    cpu_bus bus_if ();

    nmi_scheduler dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .req_magic    (req_magic),
        .req_div      (req_div),
        .req_pause    (req_pause),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .inhibit      (inhibit),
        .magic_map    (magic_map),
        .n_nmi        (n_nmi),
        .nmi_busy     (nmi_busy),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    always #5 clk28 = ~clk28;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk28);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus_if.mreq = 0; bus_if.m1 = 0; bus_if.rd = 0; bus_if.wr = 0;
        bus_if.ioreq = 0; bus_if.a = 16'h0000; bus_if.d = 8'h00;
    endtask

    task automatic frame_edge();
        n_int_next = 0;
        step();
        n_int_next = 1;
    endtask

    task automatic fetch_vec();
        bus_if.m1 = 1; bus_if.mreq = 1; bus_if.a = 16'h0066;
        step();
        bus_idle();
    endtask

    task automatic io_rd(input logic map);
        magic_map = map; bus_if.ioreq = 1; bus_if.rd = 1; bus_if.a = 16'h10FF;
        step();
        bus_idle();
        magic_map = 1;
    endtask

    task automatic io_wr(input logic map);
        magic_map = map; bus_if.ioreq = 1; bus_if.wr = 1; bus_if.a = 16'h10FF;
        bus_if.d = 8'hA5;
        step();
        bus_idle();
        magic_map = 1;
    endtask

    initial begin
        rst_n = 0; req_magic = 0; req_div = 0; req_pause = 0;
        n_int = 1; n_int_next = 1; inhibit = 0; magic_map = 1;
        bus_idle();
        step(2);
        chk("rst_n_nmi", 8'(n_nmi), 8'h01);
        chk("rst_busy", 8'(nmi_busy), 8'h00);
        chk("rst_doa", 8'(d_out_active), 8'h00);
        rst_n = 1;
        step();

        // Single magic request through to acknowledge and read-back
        req_magic = 1; step(); req_magic = 0;
        step(2);
        chk("t1_wait_busy", 8'(nmi_busy), 8'h01);
        chk("t1_wait_nmi", 8'(n_nmi), 8'h01);
        frame_edge();
        chk("t1_assert_nmi", 8'(n_nmi), 8'h00);
        step(3);
        chk("t1_hold_nmi", 8'(n_nmi), 8'h00);
        fetch_vec();
        chk("t1_ack_nmi", 8'(n_nmi), 8'h01);
        io_rd(1);
        chk("t1_rd_doa", 8'(d_out_active), 8'h01);
        chk("t1_rd_data", d_out, 8'h01);
        step();
        chk("t1_rd_doa_off", 8'(d_out_active), 8'h00);
        // Port hidden without magic_map
        io_wr(0);
        chk("t1_hidden_wr_busy", 8'(nmi_busy), 8'h01);
        io_rd(0);
        chk("t1_hidden_rd_doa", 8'(d_out_active), 8'h00);
        chk("t1_hidden_rd_busy", 8'(nmi_busy), 8'h01);
        io_wr(1);
        chk("t1_release_busy", 8'(nmi_busy), 8'h00);

        // Simultaneous div + pause: div first, pause second
        req_div = 1; req_pause = 1; step(); req_div = 0; req_pause = 0;
        step(2);
        frame_edge();
        chk("t2_g1_nmi", 8'(n_nmi), 8'h00);
        io_rd(1);
        chk("t2_g1_data", d_out, 8'h82);
        fetch_vec();
        chk("t2_g1_ack", 8'(n_nmi), 8'h01);
        io_wr(1);
        step(2);
        chk("t2_g2_wait_busy", 8'(nmi_busy), 8'h01);
        frame_edge();
        chk("t2_g2_nmi", 8'(n_nmi), 8'h00);
        io_rd(1);
        chk("t2_g2_data", d_out, 8'h04);
        fetch_vec();
        io_wr(1);
        step();
        chk("t2_done_busy", 8'(nmi_busy), 8'h00);

        // Inhibit holds off a pending magic request across frames
        inhibit = 1;
        req_magic = 1; step(); req_magic = 0;
        for (int f = 0; f < 3; f++) begin
            step(4);
            frame_edge();
            chk("t3_inhibit_nmi", 8'(n_nmi), 8'h01);
            chk("t3_inhibit_busy", 8'(nmi_busy), 8'h00);
        end
        inhibit = 0;
        step(2);
        frame_edge();
        chk("t3_release_nmi", 8'(n_nmi), 8'h00);
        fetch_vec();
        io_wr(1);
        step();

        // ASSERT without acknowledge
        req_magic = 1; step(); req_magic = 0;
        step(2);
        frame_edge();
        chk("t4_assert_nmi", 8'(n_nmi), 8'h00);
`ifdef NMI_SCHEDULER_TIMEOUT_EN
        begin
            int n = 0;
            while (n_nmi !== 1'b1 && n < 70000) begin
                step();
                n++;
            end
        end
        chk("t4_timeout_nmi", 8'(n_nmi), 8'h01);
        chk("t4_timeout_idle", 8'(nmi_busy), 8'h00);
        io_rd(1);
        chk("t4_timeout_data", d_out, 8'h11);
`else
        step(300);
        chk("t4_hold_nmi", 8'(n_nmi), 8'h00);
        chk("t4_hold_busy", 8'(nmi_busy), 8'h01);
        fetch_vec();
        io_wr(1);
        step();
`endif

        // Reset in mid-sequence with a held request
        req_magic = 1; step();
        step(2);
        frame_edge();
        chk("t5_assert_nmi", 8'(n_nmi), 8'h00);
        rst_n = 0;
        #1;
        chk("t5_async_nmi", 8'(n_nmi), 8'h01);
        chk("t5_async_busy", 8'(nmi_busy), 8'h00);
        #2 rst_n = 1;
        step(2);
        for (int f = 0; f < 2; f++) begin
            step(3);
            frame_edge();
            chk("t5_held_nmi", 8'(n_nmi), 8'h01);
            chk("t5_held_busy", 8'(nmi_busy), 8'h00);
        end
        io_rd(1);
        chk("t5_cleared_data", d_out, 8'h00);
        req_magic = 0; step();
        req_magic = 1; step(); req_magic = 0;
        step(2);
        frame_edge();
        chk("t5_repulse_nmi", 8'(n_nmi), 8'h00);
        io_rd(1);
        chk("t5_repulse_data", d_out, 8'h01);
        fetch_vec();
        io_wr(1);
        step();
        chk("t5_done_busy", 8'(nmi_busy), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
